// File: rtl/dest_reg_pipe.sv
// Write-back destination pipe: decodes rt/rd/link destination in ID and carries
// dest, write-enable and return address through STAGES registers with stall/flush.
module dest_reg_pipe #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int STAGES      = 3,
  parameter int LINK_REG    = 31,
  parameter int LINK_OFFSET = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] inst,
  input  logic [DATA_W-1:0] pc,
  input  logic              valid_in,
  input  logic              reg_write_in,
  input  logic [1:0]        dst_sel,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] src_a,
  input  logic [REG_AW-1:0] src_b,
  output logic [REG_AW-1:0] wb_dest,
  output logic              wb_we,
  output logic              wb_link,
  output logic [DATA_W-1:0] wb_link_data,
  output logic [STAGES-1:0] hit_a,
  output logic [STAGES-1:0] hit_b
);

  localparam logic [REG_AW-1:0] LINK_DEST = REG_AW'(LINK_REG);

  logic [REG_AW-1:0] rt, rd, dec_dest;
  logic              is_jalr, dec_we, dec_link;
  logic [DATA_W-1:0] dec_ld;

  // Register-field bits that never influence the destination.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst[25:21], inst[10:6]};

  always_comb begin
    rt       = REG_AW'(inst[20:16]);
    rd       = REG_AW'(inst[15:11]);
    is_jalr  = (inst[31:26] == 6'd0) && (inst[5:0] == 6'b001001);
    dec_dest = '0;
    case (dst_sel)
      2'b00:   dec_dest = rt;
      2'b01:   dec_dest = rd;
      2'b10:   dec_dest = is_jalr ? rd : LINK_DEST;
      default: dec_dest = '0;
    endcase
    dec_we   = valid_in & reg_write_in & (dst_sel != 2'b11) & (dec_dest != '0);
    dec_link = dec_we & (dst_sel == 2'b10);
    dec_ld   = pc + DATA_W'(LINK_OFFSET);
  end

  logic [STAGES-1:0] st_valid, st_we, st_link;
  logic [REG_AW-1:0] st_dest [STAGES];
  logic [DATA_W-1:0] st_ld   [STAGES];

  // Flush only ever touches stage 0, so it is resolved independently of stall;
  // the shift of stages 1.. is gated by stall alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_valid <= '0;
      st_we    <= '0;
      st_link  <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        st_dest[k] <= '0;
        st_ld[k]   <= '0;
      end
    end else begin
      if (flush) begin
        st_valid[0] <= 1'b0;
        st_we[0]    <= 1'b0;
        st_link[0]  <= 1'b0;
        st_dest[0]  <= '0;
        st_ld[0]    <= '0;
      end else if (!stall) begin
        st_valid[0] <= valid_in;
        st_we[0]    <= dec_we;
        st_link[0]  <= dec_link;
        st_dest[0]  <= dec_dest;
        st_ld[0]    <= dec_ld;
      end
      if (!stall) begin
        for (int unsigned k = 1; k < STAGES; k++) begin
          st_valid[k] <= st_valid[k-1];
          st_we[k]    <= st_we[k-1];
          st_link[k]  <= st_link[k-1];
          st_dest[k]  <= st_dest[k-1];
          st_ld[k]    <= st_ld[k-1];
        end
      end
    end
  end

  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      hit_a[k] = st_valid[k] & st_we[k] & (src_a != '0) & (st_dest[k] == src_a);
      hit_b[k] = st_valid[k] & st_we[k] & (src_b != '0) & (st_dest[k] == src_b);
    end
  end

  assign wb_dest      = st_dest[STAGES-1];
  assign wb_we        = st_we[STAGES-1];
  assign wb_link      = st_link[STAGES-1];
  assign wb_link_data = st_ld[STAGES-1];

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Scoreboard bench for dest_reg_pipe: a queue-based reference pipe predicts each
// cycle's WB outputs and hit vectors; a negedge monitor pops and compares.
module tb_dest_reg_pipe;
  localparam int S = 3;

  logic        clk = 1'b0;
  logic        rst_n, valid_in, reg_write_in, stall, flush;
  logic [31:0] inst, pc;
  logic [1:0]  dst_sel;
  logic [4:0]  src_a, src_b;
  logic [4:0]  wb_dest;
  logic        wb_we, wb_link;
  logic [31:0] wb_link_data;
  logic [S-1:0] hit_a, hit_b;

  always #5 clk = ~clk;

  dest_reg_pipe #(.DATA_W(32), .REG_AW(5), .STAGES(S), .LINK_REG(31), .LINK_OFFSET(8)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .pc(pc), .valid_in(valid_in),
    .reg_write_in(reg_write_in), .dst_sel(dst_sel), .stall(stall), .flush(flush),
    .src_a(src_a), .src_b(src_b), .wb_dest(wb_dest), .wb_we(wb_we), .wb_link(wb_link),
    .wb_link_data(wb_link_data), .hit_a(hit_a), .hit_b(hit_b)
  );

  // strict: dest/link value are defined (a real write, or a cleared bubble)
  typedef struct { bit we; bit link; bit strict; bit [4:0] dest; bit [31:0] ld; } ent_t;
  typedef struct { bit we; bit link; bit strict; bit [4:0] dest; bit [31:0] ld;
                   bit [S-1:0] ha; bit [S-1:0] hb; } exp_t;

  ent_t pipe_q[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic ent_t bubble();
    ent_t e;
    e = '{we: 0, link: 0, strict: 1, dest: 5'd0, ld: 32'd0};
    return e;
  endfunction

  function automatic ent_t decode(bit [31:0] i, bit [31:0] p, bit v, bit rw, bit [1:0] sel);
    ent_t e;
    bit [4:0] d;
    case (sel)
      2'd0:    d = i[20:16];
      2'd1:    d = i[15:11];
      2'd2:    d = (i[31:26] == 6'd0 && i[5:0] == 6'd9) ? i[15:11] : 5'd31;
      default: d = 5'd0;
    endcase
    e.we     = v && rw && sel != 2'd3 && d != 5'd0;
    e.link   = e.we && sel == 2'd2;
    e.dest   = d;
    e.ld     = p + 32'd8;
    e.strict = e.we;
    return e;
  endfunction

  task automatic drive(input bit r, input bit [31:0] i, input bit [31:0] p, input bit v,
                       input bit rw, input bit [1:0] sel, input bit st, input bit fl,
                       input bit [4:0] sa, input bit [4:0] sb);
    exp_t x;
    rst_n = r; inst = i; pc = p; valid_in = v; reg_write_in = rw;
    dst_sel = sel; stall = st; flush = fl; src_a = sa; src_b = sb;
    x.we = pipe_q[S-1].we; x.link = pipe_q[S-1].link; x.strict = pipe_q[S-1].strict;
    x.dest = pipe_q[S-1].dest; x.ld = pipe_q[S-1].ld;
    for (int k = 0; k < S; k++) begin
      x.ha[k] = pipe_q[k].we && sa != 5'd0 && pipe_q[k].dest == sa;
      x.hb[k] = pipe_q[k].we && sb != 5'd0 && pipe_q[k].dest == sb;
    end
    exp_q.push_back(x);
    @(posedge clk);
    if (!r) begin
      pipe_q.delete();
      repeat (S) pipe_q.push_back(bubble());
    end else if (st) begin
      if (fl) pipe_q[0] = bubble();
    end else begin
      pipe_q.push_front(fl ? bubble() : decode(i, p, v, rw, sel));
      void'(pipe_q.pop_back());
    end
    #1;
  endtask

  task automatic issue(input bit [31:0] i, input bit [31:0] p, input bit [1:0] sel);
    drive(1, i, p, 1, 1, sel, 0, 0, 5'd0, 5'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1, 32'd0, 32'd0, 0, 0, 2'd3, 0, 0, 5'd6, 5'd31);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if (wb_we !== x.we || wb_link !== x.link) begin
          errors++;
          $display("FAIL ctrl t=%0t we/link got %b/%b exp %b/%b", $time, wb_we, wb_link, x.we, x.link);
        end
        if (x.strict) begin
          checks++;
          if (wb_dest !== x.dest || wb_link_data !== x.ld) begin
            errors++;
            $display("FAIL data t=%0t dest/ld got %0d/%h exp %0d/%h", $time, wb_dest, wb_link_data, x.dest, x.ld);
          end
        end
        checks++;
        if (hit_a !== x.ha || hit_b !== x.hb) begin
          errors++;
          $display("FAIL hits t=%0t a/b got %b/%b exp %b/%b", $time, hit_a, hit_b, x.ha, x.hb);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : driver
    bit [31:0] ri;
    rst_n = 0; inst = '0; pc = '0; valid_in = 0; reg_write_in = 0;
    dst_sel = 2'd3; stall = 0; flush = 0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    repeat (S) pipe_q.push_back(bubble());
    #1;
    // reset held, outputs must read zero
    drive(0, 32'd0, 32'd0, 0, 0, 2'd3, 0, 0, 5'd31, 5'd0);
    drive(0, 32'd0, 32'd0, 0, 0, 2'd3, 0, 0, 5'd31, 5'd0);
    // JAL
    issue(32'h0C000010, 32'h00400020, 2'd2);
    idle(3);
    // JALR then R-type one cycle later
    issue(32'h00802809, 32'h00000100, 2'd2);
    issue(32'h00A63020, 32'h00000104, 2'd1);
    idle(3);
    // write to $0 suppressed, link value wrap
    issue(32'h20000005, 32'h00000200, 2'd0);
    issue(32'h0C000010, 32'hFFFFFFFC, 2'd2);
    idle(3);
    // stall then flush
    issue(32'h00A63020, 32'h00000300, 2'd1);
    drive(1, 32'h00004020, 32'h304, 1, 1, 2'd1, 1, 0, 5'd6, 5'd8);
    drive(1, 32'h00004020, 32'h304, 1, 1, 2'd1, 1, 0, 5'd6, 5'd8);
    drive(1, 32'h00004020, 32'h304, 1, 1, 2'd1, 0, 1, 5'd6, 5'd8);
    idle(3);
    // stall + flush together
    issue(32'h00A63020, 32'h00000400, 2'd1);
    issue(32'h00004820, 32'h00000404, 2'd1);
    drive(1, 32'h00004020, 32'h408, 1, 1, 2'd1, 1, 1, 5'd6, 5'd9);
    drive(1, 32'h00000000, 32'h40C, 0, 0, 2'd3, 1, 0, 5'd6, 5'd9);
    idle(3);
    // forwarding: dest 8 in stages 0 and 2
    issue(32'h00004020, 32'h00000500, 2'd1);
    issue(32'h00004820, 32'h00000504, 2'd1);
    issue(32'h00004020, 32'h00000508, 2'd1);
    drive(1, 32'd0, 32'd0, 0, 0, 2'd3, 1, 0, 5'd8, 5'd0);
    idle(3);
    // reset with entries in flight
    issue(32'h00A63020, 32'h600, 2'd1);
    issue(32'h00004020, 32'h604, 2'd1);
    issue(32'h0C000010, 32'h608, 2'd2);
    drive(0, 32'h00004820, 32'h60C, 1, 1, 2'd1, 0, 0, 5'd6, 5'd8);
    issue(32'h00004820, 32'h610, 2'd1);
    issue(32'h00A63020, 32'h614, 2'd1);
    issue(32'h00004020, 32'h618, 2'd1);
    idle(3);
    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      ri = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        ri[31:26] = 6'd0;
        ri[5:0]   = 6'b001001;
      end
      ri[20:16] = 5'($urandom_range(0, 7));
      ri[15:11] = 5'($urandom_range(0, 7));
      drive($urandom_range(0, 99) >= 2, ri, $urandom, $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 4) == 0,
            $urandom_range(0, 7) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
